// File: rtl/lsu_mem_ctrl.sv
// Load/store unit data-memory controller.
// Accepts one RV32I load/store at a time from the execute stage, checks
// alignment/legality, issues a single request on the data-memory bus and
// returns a one-cycle completion pulse with load data or an error flag.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req_valid/req_ready       request handshake (ready only in IDLE)
//   req_we, req_funct3        store flag, RV32I funct3
//   req_addr, req_wdata       effective byte address, store data
//   resp_valid                one-cycle completion pulse
//   resp_rdata, resp_err      shifted load word, error flag (held until next response)
//   mem_req/we/addr/be/wdata  data-memory request bus (active only in REQ)
//   mem_gnt                   request granted
//   mem_rvalid, mem_rdata     load data return (only honoured in WAIT)
module lsu_mem_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic             we_q;
  logic [1:0]       off_q;
  logic             req_ready_q;
  logic             resp_valid_q;
  logic [31:0]      resp_rdata_q;
  logic             resp_err_q;
  logic             mem_req_q;
  logic             mem_we_q;
  logic [31:0]      mem_addr_q;
  logic [3:0]       mem_be_q;
  logic [31:0]      mem_wdata_q;

  logic             legal_c;
  logic [3:0]       be_c;
  logic [31:0]      wdata_c;

  // Decode the incoming request: legality, byte enables, lane-replicated store data.
  always_comb begin
    legal_c = 1'b1;
    be_c    = 4'b1111;
    wdata_c = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        be_c    = 4'b0001 << req_addr[1:0];
        wdata_c = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        if (req_addr[0]) legal_c = 1'b0;
        be_c    = 4'b0011 << req_addr[1:0];
        wdata_c = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        if (req_addr[1:0] != 2'b00) legal_c = 1'b0;
      end
      default: legal_c = 1'b0;
    endcase
    // Stores have no unsigned variants; load funct3=110 (LWU) does not exist in RV32I.
    if (req_we && req_funct3[2]) legal_c = 1'b0;
    if (!req_we && (req_funct3 == 3'b110)) legal_c = 1'b0;
  end

  // Control FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      off_q        <= 2'b00;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= '0;
      mem_wdata_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            we_q        <= req_we;
            off_q       <= req_addr[1:0];
            if (legal_c) begin
              state_q     <= REQ;
              mem_req_q   <= 1'b1;
              mem_we_q    <= req_we;
              mem_addr_q  <= {req_addr[31:2], 2'b00};
              mem_be_q    <= be_c;
              mem_wdata_q <= wdata_c;
            end else begin
              // Rejected requests never reach the memory bus.
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end
          end
        end
        REQ: begin
          if (mem_gnt) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            if (we_q) begin
              // Stores complete on grant; no data phase.
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b0;
              resp_rdata_q <= '0;
            end else begin
              state_q <= WAIT;
              cnt_q   <= '0;
            end
          end
        end
        WAIT: begin
          // Returned data wins over a timeout in the same cycle.
          if (mem_rvalid) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= mem_rdata >> {off_q, 3'b000};
          end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= '0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        RESP: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
        end
        default: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;

endmodule
